res_sched: RTL and testbench
============================

# res_sched

Per-layer controller for the residual adder. It accepts one layer descriptor at a time, issues the 1-bit residual-enable instruction to the adder, and fetches residual data as read-burst commands. Fetch is throttled by a credit counter so the adder's 512-entry residual FIFO never overflows. The block monitors the adder's feature-output input stream to detect end of layer, checks the beat count, and reports completion and errors.

## Interface
- AXI_DATA_WIDTH, 128: stream beat width in bits; bytes per beat = AXI_DATA_WIDTH/8.
- ADDR_WIDTH, 32: residual base address width.
- LEN_WIDTH, 16: beat-count field width.
- BURST_BEATS, 64: maximum beats per read command.
- RES_FIFO_DEPTH, 512: residual FIFO capacity in beats (credit limit).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset. Asynchronous, active-high; only clk is a clock.
- s_axis_layer_tready  out  1  descriptor accept.
- s_axis_layer_tvalid  in  1  descriptor valid.
- s_axis_layer_tdata  in  1+LEN_WIDTH+ADDR_WIDTH  descriptor fields: [0] res_en, [LEN_WIDTH:1] num_beats, [ADDR_WIDTH+LEN_WIDTH:LEN_WIDTH+1] res_base.
- m_axis_res_instr_tready  in  1  adder instruction ready.
- m_axis_res_instr_tvalid  out  1  instruction valid.
- m_axis_res_instr_tdata  out  1  res_en of the current layer.
- m_axis_rdcmd_tready  in  1  read-command accept.
- m_axis_rdcmd_tvalid  out  1  read command valid.
- m_axis_rdcmd_tdata  out  ADDR_WIDTH+LEN_WIDTH  read command: [ADDR_WIDTH-1:0] address, upper bits = beat count (1..BURST_BEATS).
- mon_lc2res_tvalid, mon_lc2res_tready, mon_lc2res_tlast, mon_lc2res_tuser  in  1 each  passive tap of the adder's feature-output input handshake.
- layer_done  out  1  one-cycle pulse when a layer completes.
- status  out  32  [31:16] count of completed layers (wraps); [3] err_len, sticky; [2] err_zero, sticky; [1:0] state.

## Operation
- States: IDLE=0, INSTR=1, FETCH=2, WAIT=3.
- IDLE: s_axis_layer_tready=1. On handshake, latch the descriptor; clear beat_cnt and remaining=num_beats.
  - If num_beats==0: set err_zero, pulse layer_done next cycle, increment the completed count, stay in IDLE. No instruction and no fetch are issued.
  - Otherwise go to INSTR.
- INSTR: assert instr_tvalid with tdata=res_en, held until handshake. Next state is FETCH if res_en=1, else WAIT.
- FETCH: a burst is len=min(remaining, BURST_BEATS). Present a command only when outstanding+len ≤ RES_FIFO_DEPTH.
  - Address and len are registered and stay stable while tvalid=1 && tready=0.
  - On handshake: address += len·AXI_DATA_WIDTH/8; remaining -= len; outstanding += len.
  - When remaining reaches 0, go to WAIT.
- outstanding: decrements by 1 on each monitored handshake (mon tvalid & tready) while res_en=1. Simultaneous increment and decrement are both applied in the same cycle (net change).
- beat_cnt: increments on every monitored handshake in INSTR, FETCH and WAIT. Handshakes in IDLE are ignored.
- End of layer: a monitored handshake with tlast & tuser, in INSTR, FETCH or WAIT.
  - Go to IDLE and pulse layer_done next cycle.
  - If the final beat_cnt (including the end beat) ≠ num_beats, or remaining ≠ 0, set err_len.
  - remaining is dropped and any pending rdcmd is withdrawn. outstanding is cleared.
- All counters and sticky errors clear only on rst.

## Timing
- Reset values: s_axis_layer_tready=0 while rst is asserted, 1 on the first cycle after release; instr_tvalid=0, rdcmd_tvalid=0, all tdata=0, layer_done=0, status=0.
- Descriptor handshake at cycle N: instr_tvalid=1 at N+1.
- Instruction handshake at M (res_en=1): first rdcmd_tvalid at M+1 if credit allows.
- Commands are back-to-back: after a handshake at cycle K, the next command is valid at K+1 when credit allows.
- End-of-layer beat at cycle E: layer_done=1 and state=IDLE at E+1; the next descriptor is accepted no earlier than E+1.
- Outputs are fully registered. tready inputs do not combinationally feed any output.
- rst asserted mid-layer: all outputs return to reset values immediately; the pending command is abandoned.

## Test plan
- res_en=1, num_beats=200, base=0x1000, BURST_BEATS=64, all ready held 1, 200 monitored beats with the last carrying tlast+tuser -> commands (0x1000,64), (0x1400,64), (0x1800,64), (0x1C00,8); one layer_done; status[31:16]=1; errors 0.
- res_en=0, num_beats=10 -> instruction tdata=0, no rdcmd; layer_done one cycle after the 10th beat.
- Credit stall: num_beats=1024, monitor idle -> exactly 8 commands of 64 beats (512 outstanding) then rdcmd_tvalid=0; one monitored beat keeps it 0 (511+64>512); after 64 beats the next command issues.
- rdcmd_tready=0 for 5 cycles -> tvalid stays 1 with tdata unchanged; exactly one handshake recorded.
- num_beats=0 -> err_zero=1, layer_done pulse, no instruction; a following num_beats=4 layer completes normally.
- Early end: num_beats=100, tlast+tuser on beat 50 -> err_len=1, pending command dropped, IDLE; rst mid-FETCH -> all outputs 0 immediately.

Source files
------------

// File: rtl/res_sched.sv
// Residual-adder layer controller: issues the res_en instruction, fetches residual data in
// credit-limited read bursts and tracks the adder's output stream to detect end of layer.
module res_sched #(
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned BURST_BEATS    = 64,
  parameter int unsigned RES_FIFO_DEPTH = 512
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            s_axis_layer_tready,
  input  logic                            s_axis_layer_tvalid,
  input  logic [ADDR_WIDTH+LEN_WIDTH:0]   s_axis_layer_tdata,
  input  logic                            m_axis_res_instr_tready,
  output logic                            m_axis_res_instr_tvalid,
  output logic                            m_axis_res_instr_tdata,
  input  logic                            m_axis_rdcmd_tready,
  output logic                            m_axis_rdcmd_tvalid,
  output logic [ADDR_WIDTH+LEN_WIDTH-1:0] m_axis_rdcmd_tdata,
  input  logic                            mon_lc2res_tvalid,
  input  logic                            mon_lc2res_tready,
  input  logic                            mon_lc2res_tlast,
  input  logic                            mon_lc2res_tuser,
  output logic                            layer_done,
  output logic [31:0]                     status
);

  localparam int unsigned BeatBytes = AXI_DATA_WIDTH / 8;
  localparam int unsigned CredW     = $clog2(RES_FIFO_DEPTH + BURST_BEATS + 1) + 1;
  localparam logic [LEN_WIDTH-1:0] BurstLen = LEN_WIDTH'(BURST_BEATS);
  localparam logic [CredW-1:0]     DepthLim = CredW'(RES_FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle = 2'd0, StInstr = 2'd1, StFetch = 2'd2, StWait = 2'd3} state_e;

  state_e                state_q;
  logic                  res_en_q;
  logic [LEN_WIDTH-1:0]  num_beats_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [CredW-1:0]      outstanding_q;
  logic [LEN_WIDTH:0]    beat_cnt_q;
  logic [15:0]           done_cnt_q;
  logic                  err_len_q, err_zero_q, layer_done_q, layer_tready_q;
  logic                  instr_valid_q, instr_data_q, rd_valid_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [LEN_WIDTH-1:0]  rd_len_q;

  logic                  d_res_en;
  logic [LEN_WIDTH-1:0]  d_num;
  logic [ADDR_WIDTH-1:0] d_base;
  logic                  desc_hs, instr_hs, rd_hs, mon_hs, active, eol, out_dec, credit_ok;
  logic [LEN_WIDTH-1:0]  hs_len, rem_next, len_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [CredW-1:0]      out_next;
  logic [LEN_WIDTH:0]    beat_next;

  always_comb begin
    d_res_en  = s_axis_layer_tdata[0];
    d_num     = s_axis_layer_tdata[LEN_WIDTH:1];
    d_base    = s_axis_layer_tdata[ADDR_WIDTH+LEN_WIDTH:LEN_WIDTH+1];
    desc_hs   = layer_tready_q & s_axis_layer_tvalid;
    instr_hs  = instr_valid_q & m_axis_res_instr_tready;
    rd_hs     = rd_valid_q & m_axis_rdcmd_tready;
    mon_hs    = mon_lc2res_tvalid & mon_lc2res_tready;
    active    = (state_q != StIdle);
    eol       = active & mon_hs & mon_lc2res_tlast & mon_lc2res_tuser;
    // Credit never drops below zero even if the adder emits beats ahead of fetched data.
    out_dec   = active & res_en_q & mon_hs & (outstanding_q != '0);
    hs_len    = rd_hs ? rd_len_q : '0;
    out_next  = outstanding_q + CredW'(hs_len) - CredW'(out_dec);
    rem_next  = remaining_q - hs_len;
    addr_next = addr_q + ADDR_WIDTH'(hs_len) * ADDR_WIDTH'(BeatBytes);
    len_next  = (rem_next > BurstLen) ? BurstLen : rem_next;
    credit_ok = (out_next + CredW'(len_next)) <= DepthLim;
    beat_next = beat_cnt_q + (LEN_WIDTH + 1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      res_en_q       <= 1'b0;
      num_beats_q    <= '0;
      addr_q         <= '0;
      remaining_q    <= '0;
      outstanding_q  <= '0;
      beat_cnt_q     <= '0;
      done_cnt_q     <= '0;
      err_len_q      <= 1'b0;
      err_zero_q     <= 1'b0;
      layer_done_q   <= 1'b0;
      layer_tready_q <= 1'b0;
      instr_valid_q  <= 1'b0;
      instr_data_q   <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_addr_q      <= '0;
      rd_len_q       <= '0;
    end else begin
      layer_done_q  <= 1'b0;
      outstanding_q <= out_next;
      remaining_q   <= rem_next;
      addr_q        <= addr_next;
      if (active && mon_hs) beat_cnt_q <= beat_next;
      unique case (state_q)
        StIdle: begin
          layer_tready_q <= !(desc_hs && d_num != '0);
          if (desc_hs) begin
            res_en_q    <= d_res_en;
            num_beats_q <= d_num;
            addr_q      <= d_base;
            // Layers without residual fetch have nothing remaining to request.
            remaining_q <= d_res_en ? d_num : '0;
            beat_cnt_q  <= '0;
            if (d_num == '0) begin
              err_zero_q   <= 1'b1;
              layer_done_q <= 1'b1;
              done_cnt_q   <= done_cnt_q + 16'd1;
            end else begin
              state_q       <= StInstr;
              instr_valid_q <= 1'b1;
              instr_data_q  <= d_res_en;
            end
          end
        end
        StInstr: begin
          if (instr_hs) begin
            instr_valid_q <= 1'b0;
            if (res_en_q) begin
              state_q    <= StFetch;
              rd_valid_q <= (rem_next != '0) && credit_ok;
              rd_addr_q  <= addr_next;
              rd_len_q   <= len_next;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StFetch: begin
          // A presented command is frozen until accepted.
          if (rd_hs || !rd_valid_q) begin
            if (rem_next == '0) begin
              state_q    <= StWait;
              rd_valid_q <= 1'b0;
            end else begin
              rd_valid_q <= credit_ok;
              rd_addr_q  <= addr_next;
              rd_len_q   <= len_next;
            end
          end
        end
        StWait: ;
        default: state_q <= StIdle;
      endcase
      if (eol) begin
        state_q        <= StIdle;
        layer_done_q   <= 1'b1;
        done_cnt_q     <= done_cnt_q + 16'd1;
        instr_valid_q  <= 1'b0;
        rd_valid_q     <= 1'b0;
        outstanding_q  <= '0;
        remaining_q    <= '0;
        layer_tready_q <= 1'b1;
        if ((beat_next != {1'b0, num_beats_q}) || (rem_next != '0)) err_len_q <= 1'b1;
      end
    end
  end

  assign s_axis_layer_tready     = layer_tready_q;
  assign m_axis_res_instr_tvalid = instr_valid_q;
  assign m_axis_res_instr_tdata  = instr_data_q;
  assign m_axis_rdcmd_tvalid     = rd_valid_q;
  assign m_axis_rdcmd_tdata      = {rd_len_q, rd_addr_q};
  assign layer_done              = layer_done_q;
  assign status = {done_cnt_q, 12'd0, err_len_q, err_zero_q, state_q};

endmodule

// File: tb/tb_res_sched.sv
// Randomized bench for res_sched: a transaction-level model predicts commands, credit,
// state and completion from layer-level arithmetic and checks every cycle.
module tb_res_sched;
  localparam int AW = 32, LW = 16, BB = 64, DEPTH = 512, BYTES = 16;

  logic              clk, rst;
  logic              s_tready, s_tvalid;
  logic [AW+LW:0]    s_tdata;
  logic              ins_tready, ins_tvalid, ins_tdata;
  logic              rd_tready, rd_tvalid;
  logic [AW+LW-1:0]  rd_tdata;
  logic              mon_tvalid, mon_tready, mon_tlast, mon_tuser;
  logic              layer_done;
  logic [31:0]       status;

  res_sched #(.AXI_DATA_WIDTH(128), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BURST_BEATS(BB),
              .RES_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_layer_tready(s_tready), .s_axis_layer_tvalid(s_tvalid),
    .s_axis_layer_tdata(s_tdata),
    .m_axis_res_instr_tready(ins_tready), .m_axis_res_instr_tvalid(ins_tvalid),
    .m_axis_res_instr_tdata(ins_tdata),
    .m_axis_rdcmd_tready(rd_tready), .m_axis_rdcmd_tvalid(rd_tvalid),
    .m_axis_rdcmd_tdata(rd_tdata),
    .mon_lc2res_tvalid(mon_tvalid), .mon_lc2res_tready(mon_tready),
    .mon_lc2res_tlast(mon_tlast), .mon_lc2res_tuser(mon_tuser),
    .layer_done(layer_done), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Layer-level reference state
  bit     in_layer, cur_res_en, pend_done, desc_taken, exp_err_len, exp_err_zero;
  int     cur_num, acc, cmd_idx, out_m, beats_sent, instr_seen, done_cnt;
  longint cur_base;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int exp_state();
    if (!in_layer) return 0;
    if (instr_seen == 0) return 1;
    if (cur_res_en && acc < cur_num) return 2;
    return 3;
  endfunction

  task automatic reset_model();
    in_layer = 0; cur_res_en = 0; pend_done = 0; desc_taken = 0;
    exp_err_len = 0; exp_err_zero = 0; cur_num = 0; acc = 0; cmd_idx = 0;
    out_m = 0; beats_sent = 0; instr_seen = 0; done_cnt = 0; cur_base = 0;
  endtask

  task automatic idle_inputs();
    s_tvalid = 0; ins_tready = 0; rd_tready = 0;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; mon_tuser = 0;
  endtask

  // One clock: account for handshakes about to occur, then check outputs after the edge.
  task automatic step();
    bit             eol, stall, exp_rd;
    logic [AW+LW-1:0] held;
    int             elen;
    longint         eaddr;
    eol = 0;
    if (rd_tvalid && rd_tready) begin
      eaddr = (cur_base + longint'(cmd_idx) * BB * BYTES) & 64'hFFFF_FFFF;
      elen  = min_i(BB, cur_num - cmd_idx * BB);
      chk("rdcmd_addr", rd_tdata[AW-1:0], eaddr);
      chk("rdcmd_len", rd_tdata[AW+LW-1:AW], elen);
      acc += elen; out_m += elen; cmd_idx++;
    end
    if (ins_tvalid && ins_tready) begin
      chk("instr_data", ins_tdata, cur_res_en);
      instr_seen++;
    end
    if (mon_tvalid && mon_tready && in_layer) begin
      beats_sent++;
      if (cur_res_en && out_m > 0) out_m--;
      eol = mon_tlast && mon_tuser;
    end
    if (eol) begin
      if (beats_sent != cur_num || (cur_res_en && acc != cur_num)) exp_err_len = 1;
      done_cnt++; in_layer = 0; out_m = 0; pend_done = 1;
    end
    if (s_tready && s_tvalid) begin
      cur_res_en = s_tdata[0];
      cur_num    = int'(s_tdata[LW:1]);
      cur_base   = longint'(s_tdata[AW+LW:LW+1]);
      acc = 0; cmd_idx = 0; out_m = 0; beats_sent = 0; instr_seen = 0; desc_taken = 1;
      if (cur_num == 0) begin
        exp_err_zero = 1; done_cnt++; pend_done = 1;
      end else begin
        in_layer = 1;
      end
    end
    stall = rd_tvalid && !rd_tready && !eol;
    held  = rd_tdata;
    @(posedge clk); #1;
    chk("layer_done", layer_done, pend_done);
    pend_done = 0;
    if (stall) chk("rdcmd_hold", rd_tdata, held);
    chk("layer_tready", s_tready, !in_layer);
    chk("instr_valid", ins_tvalid, in_layer && instr_seen == 0);
    exp_rd = in_layer && cur_res_en && instr_seen > 0 && acc < cur_num &&
             (out_m + min_i(BB, cur_num - acc) <= DEPTH);
    chk("rdcmd_valid", rd_tvalid, exp_rd);
    chk("state", status[1:0], exp_state());
    chk("done_cnt", status[31:16], done_cnt & 16'hFFFF);
    chk("err_len", status[3], exp_err_len);
    chk("err_zero", status[2], exp_err_zero);
    chk("status_rsvd", status[15:4], 0);
  endtask

  task automatic start_layer(input bit res_en, input int num, input longint base);
    s_tdata    = {base[AW-1:0], num[LW-1:0], res_en};
    s_tvalid   = 1;
    desc_taken = 0;
    for (int i = 0; i < 100 && !desc_taken; i++) step();
    s_tvalid = 0;
    chk("desc_accept", desc_taken, 1);
  endtask

  task automatic drive_layer(input int target, input int stall_pct, input int mon_pct,
                             input bit hold_first);
    int stall_left, guard, r;
    bit allowed;
    stall_left = hold_first ? 5 : 0;
    guard = 0;
    while (in_layer && guard < 40000) begin
      ins_tready = ($urandom % 4) != 0;
      if (stall_left > 0 && rd_tvalid) begin
        rd_tready = 0;
        stall_left--;
      end else begin
        rd_tready = ($urandom % 100) >= stall_pct;
      end
      allowed    = instr_seen > 0 && (!cur_res_en || out_m > 0) && beats_sent < target;
      mon_tvalid = ($urandom % 100) < mon_pct;
      mon_tready = allowed && (($urandom % 4) != 0);
      if (beats_sent + 1 == target) begin
        mon_tlast = 1; mon_tuser = 1;
      end else begin
        r = $urandom % 3;
        mon_tlast = (r == 1); mon_tuser = (r == 2);
      end
      step();
      guard++;
    end
    chk("layer_end", in_layer, 0);
    idle_inputs();
  endtask

  task automatic run_layer(input bit res_en, input int num, input longint base,
                           input int target, input int stall_pct, input int mon_pct,
                           input bit hold_first);
    start_layer(res_en, num, base);
    if (num == 0) begin
      chk("zero_no_instr", instr_seen, 0);
      chk("zero_no_cmd", cmd_idx, 0);
      return;
    end
    drive_layer(target, stall_pct, mon_pct, hold_first);
    if (target == num) begin
      chk("instr_count", instr_seen, 1);
      chk("cmd_count", cmd_idx, res_en ? (num + BB - 1) / BB : 0);
    end
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      mon_tvalid = $urandom % 2; mon_tready = $urandom % 2;
      mon_tlast  = $urandom % 2; mon_tuser  = $urandom % 2;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    bit en;
    int num, tgt;
    reset_model();
    idle_inputs();
    s_tdata = '0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", s_tready, 0);
    chk("rst_instr_valid", ins_tvalid, 0);
    chk("rst_rdcmd_valid", rd_tvalid, 0);
    chk("rst_status", status, 0);
    rst = 0;
    step();

    // Four bursts from 0x1000, all ready
    run_layer(1, 200, 64'h1000, 200, 0, 80, 0);
    chk("plan1_done_cnt", status[31:16], 1);
    chk("plan1_errs", status[3:2], 0);

    // No residual: no commands
    run_layer(0, 10, 64'h2000, 10, 0, 80, 0);
    idle_noise(4);

    // Credit stall: 8 bursts fill the FIFO, one beat is not enough, 64 beats are
    start_layer(1, 1024, 64'h2_0000);
    ins_tready = 1; rd_tready = 1;
    repeat (20) step();
    chk("credit_cmds", cmd_idx, 8);
    chk("credit_stall", rd_tvalid, 0);
    mon_tvalid = 1; mon_tready = 1;
    step();
    mon_tvalid = 0; mon_tready = 0;
    repeat (3) step();
    chk("credit_one_beat", rd_tvalid, 0);
    mon_tvalid = 1; mon_tready = 1;
    repeat (63) step();
    chk("credit_resume", rd_tvalid, 1);
    mon_tvalid = 0; mon_tready = 0;
    drive_layer(1024, 0, 70, 0);
    chk("credit_err_len", status[3], 0);

    // Held command: 5 stalled cycles, one handshake
    run_layer(1, 64, 64'h4000, 64, 0, 70, 1);
    chk("hold_one_hs", cmd_idx, 1);

    // Zero-length layer then a normal one
    run_layer(1, 0, 64'h5000, 0, 0, 70, 0);
    chk("zero_err_zero", status[2], 1);
    run_layer(1, 4, 64'h6000, 4, 0, 70, 0);

    // Early end at beat 50 of 100
    run_layer(1, 100, 64'h7000, 50, 0, 70, 0);
    chk("early_err_len", status[3], 1);

    for (int i = 0; i < 12; i++) begin
      en  = $urandom % 2;
      num = $urandom_range(1, 600);
      tgt = (($urandom % 5) == 0) ? $urandom_range(1, num) : num;
      run_layer(en, num, longint'($urandom), tgt, $urandom_range(0, 60),
                $urandom_range(30, 90), 0);
      idle_noise($urandom_range(0, 3));
    end

    // Reset while a command is pending
    start_layer(1, 300, 64'h8000);
    ins_tready = 1; rd_tready = 0;
    repeat (4) step();
    chk("pre_rst_pending", rd_tvalid, 1);
    #2 rst = 1;
    #1;
    chk("midrst_tready", s_tready, 0);
    chk("midrst_instr_valid", ins_tvalid, 0);
    chk("midrst_instr_data", ins_tdata, 0);
    chk("midrst_rdcmd_valid", rd_tvalid, 0);
    chk("midrst_rdcmd_data", rd_tdata, 0);
    chk("midrst_done", layer_done, 0);
    chk("midrst_status", status, 0);
    idle_inputs();
    reset_model();
    @(posedge clk); #1;
    chk("midrst_tready_held", s_tready, 0);
    rst = 0;
    step();
    run_layer(1, 70, 64'h9000, 70, 20, 70, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
